fetch_stage: RTL



---
 rtl/pd_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pd_pkg.sv
// pd_pkg: shared types and constants for the PD core front end.
// Fetch bundle, reset PC, canonical NOP and fetch FSM states.
package pd_pkg;

    localparam int PD_AWIDTH = 32;
    localparam int PD_DWIDTH = 32;

    localparam logic [31:0] PD_BASE_ADDR = 32'h0100_0000;
    localparam logic [31:0] PD_NOP       = 32'h0000_0013;

    typedef struct packed {
        logic [PD_AWIDTH-1:0] pc;
        logic [PD_DWIDTH-1:0] insn;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_REDIR
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small circular buffer with flush, occupancy count and head.
// Flush wins over a same-cycle push, so nothing survives a redirect.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output T                             head
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T               mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and issues reads to a 1-cycle imem.
// Responses land in a small buffer that feeds decode over valid/ready.
module fetch_stage
    import pd_pkg::*;
#(
    parameter int                AWIDTH    = PD_AWIDTH,
    parameter int                DWIDTH    = PD_DWIDTH,
    parameter logic [AWIDTH-1:0] BASE_ADDR = PD_BASE_ADDR,
    parameter int                DEPTH     = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic [DWIDTH-1:0] imem_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              f_valid_o,
    input  logic              f_ready_i,
    output logic [AWIDTH-1:0] f_pc_o,
    output logic [DWIDTH-1:0] f_insn_o
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] inflight_pc_q;
    logic              inflight_q;
    logic              pop;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              credit_ok;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // fetch state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // a redirect always parks the FSM for one cycle in S_REDIR
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_BOOT:  state_nxt = redirect_i ? S_REDIR : S_RUN;
            S_RUN:   state_nxt = redirect_i ? S_REDIR : S_RUN;
            S_REDIR: state_nxt = redirect_i ? S_REDIR : S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

    // credit check: buffered + in-flight, less what leaves this cycle
    always_comb begin
        occupancy = {1'b0, count}
                  + (CW + 1)'(inflight_q)
                  - (CW + 1)'(pop);
        credit_ok = occupancy < (CW + 1)'(DEPTH);
    end

    // request only while running, never in a redirect cycle
    always_comb begin
        imem_req_o = 1'b0;
        if (state == S_RUN && !redirect_i) begin
            imem_req_o = credit_ok;
        end
    end

    assign imem_addr_o = pc_q;

    // PC: redirect target is word-aligned, otherwise advance on issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= BASE_ADDR;
        end else if (redirect_i) begin
            pc_q <= redirect_pc_i & ~AWIDTH'(3);
        end else if (imem_req_o) begin
            pc_q <= pc_q + AWIDTH'(4);
        end
    end

    // in-flight tracking; a redirect clears it so the reply is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= imem_req_o;
            if (imem_req_o) begin
                inflight_pc_q <= pc_q;
            end
        end
    end

    assign push_entry.pc   = inflight_pc_q;
    assign push_entry.insn = imem_data_i;
    assign pop             = f_valid_o & f_ready_i;

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_i),
        .count     (count),
        .head      (head)
    );

    assign f_valid_o = (count != '0);
    assign f_pc_o    = f_valid_o ? head.pc   : '0;
    assign f_insn_o  = f_valid_o ? head.insn : '0;

endmodule
